data_mem_responder: RTL and testbench

//   Memory-side responder for the pipeline's MEM stage; replaces the zero-latency data memory.

---
 rtl/data_mem_responder.sv | 148 ++++++++++++++
 tb/tb_data_mem_responder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: accepts one load/store at a time, freezes the pipeline
// while it is in flight and completes it LATENCY cycles after acceptance.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        misalign_o
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic            mis_q, mis_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     data_q, data_d;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            req_s;
    logic            stall_s;
    logic            acc_en_s;
    logic            acc_wr_s;
    logic [IW-1:0]   acc_idx_s;
    logic [31:0]     acc_wdata_s;
    logic            mem_we_s;
    logic            unused_s;

    assign req_s    = MemRead_i | MemWrite_i;
    assign unused_s = ^addr_i[31:IW+2];

    // Next-state, request capture and storage-access decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        mis_d       = mis_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        stall_s     = 1'b0;
        acc_en_s    = 1'b0;
        acc_wr_s    = wr_q;
        acc_idx_s   = idx_q;
        acc_wdata_s = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    stall_s = 1'b1;
                    wr_d    = MemWrite_i;
                    mis_d   = |addr_i[1:0];
                    idx_d   = addr_i[IW+1:2];
                    wdata_d = data_i;
                    if (|addr_i[1:0]) begin
                        state_d = S_DONE;
                    end else if (LATENCY == 1) begin
                        // Single-cycle latency commits straight from the live inputs
                        state_d     = S_DONE;
                        acc_en_s    = 1'b1;
                        acc_wr_s    = MemWrite_i;
                        acc_idx_s   = addr_i[IW+1:2];
                        acc_wdata_s = data_i;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                stall_s = 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    acc_en_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        data_d = data_q;
        if (acc_en_s && !acc_wr_s) begin
            data_d = mem_q[acc_idx_s];
        end else begin
            data_d = data_q;
        end
    end

    assign mem_we_s = acc_en_s & acc_wr_s & rst_n_i;

    // Control and load-data registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0000_0000;
            data_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            mis_q   <= mis_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[acc_idx_s] <= acc_wdata_s;
        end
    end

    assign data_o     = data_q;
    assign stall_o    = stall_s & rst_n_i;
    assign done_o     = (state_q == S_DONE);
    assign misalign_o = (state_q == S_DONE) & mis_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder at LATENCY=3 and LATENCY=1.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        rd3, wr3, rd1, wr1;
    logic [31:0] addr3, wdat3, addr1, wdat1;
    logic [31:0] data3, data1;
    logic        stall3, done3, mis3, stall1, done1, mis1;

    int vectors;
    int miscompares;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .MemRead_i(rd3), .MemWrite_i(wr3),
        .addr_i(addr3), .data_i(wdat3), .data_o(data3), .stall_o(stall3),
        .done_o(done3), .misalign_o(mis3)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .MemRead_i(rd1), .MemWrite_i(wr1),
        .addr_i(addr1), .data_i(wdat1), .data_o(data1), .stall_o(stall1),
        .done_o(done1), .misalign_o(mis1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request at the start of cycle T, expect stall for lat cycles then done.
    // Inputs stay held through DONE, as the frozen EX/MEM register would hold them.
    task automatic req(input bit sel, input string tag, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input int lat,
                       input logic exp_mis);
        @(posedge clk); #1;
        if (sel) begin rd1 = rd; wr1 = wr; addr1 = a; wdat1 = d; end
        else     begin rd3 = rd; wr3 = wr; addr3 = a; wdat3 = d; end
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk({tag, "_stall"}, 32'(sel ? stall1 : stall3), 32'd1);
            chk({tag, "_nodone"}, 32'(sel ? done1 : done3), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_done"}, 32'(sel ? done1 : done3), 32'd1);
        chk({tag, "_stall_done"}, 32'(sel ? stall1 : stall3), 32'd0);
        chk({tag, "_mis"}, 32'(sel ? mis1 : mis3), 32'(exp_mis));
    endtask

    task automatic idle_inputs();
        @(posedge clk); #1;
        rd3 = 1'b0; wr3 = 1'b0; addr3 = 32'h0; wdat3 = 32'h0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; wdat1 = 32'h0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        rd3 = 1'b1; wr3 = 1'b0; addr3 = 32'h0; wdat3 = 32'h0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; wdat1 = 32'h0;

        // Reset held with a request present: outputs must stay quiet
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall3), 32'd0);
        chk("rst_done", 32'(done3), 32'd0);
        chk("rst_data", data3, 32'h0);
        chk("rst_mis", 32'(mis3), 32'd0);
        rd3 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_stall", 32'(stall3), 32'd0);
            chk("idle_done", 32'(done3), 32'd0);
            chk("idle_data", data3, 32'h0);
        end

        // Store then immediate load to the same word (load done lands at T+7)
        req(1'b0, "st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 1'b0);
        chk("st10_data_keep", data3, 32'h0);
        req(1'b0, "ld10", 1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0);
        chk("ld10_data", data3, 32'hDEADBEEF);

        // Address wrap: 0x400 maps onto word 0
        req(1'b0, "st400", 1'b0, 1'b1, 32'h400, 32'h1234, 3, 1'b0);
        req(1'b0, "ld0", 1'b1, 1'b0, 32'h0, 32'h0, 3, 1'b0);
        chk("ld0_data", data3, 32'h1234);

        // Misaligned requests complete on the next cycle without touching storage
        req(1'b0, "ld13", 1'b1, 1'b0, 32'h13, 32'h0, 1, 1'b1);
        chk("ld13_data_keep", data3, 32'h1234);
        req(1'b0, "st12", 1'b0, 1'b1, 32'h12, 32'h99, 1, 1'b1);
        req(1'b0, "ld10b", 1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0);
        chk("ld10b_data", data3, 32'hDEADBEEF);

        // Read and write together behave as a store
        req(1'b0, "rw20", 1'b1, 1'b1, 32'h20, 32'h55, 3, 1'b0);
        chk("rw20_data_keep", data3, 32'hDEADBEEF);
        req(1'b0, "ld20", 1'b1, 1'b0, 32'h20, 32'h0, 3, 1'b0);
        chk("ld20_data", data3, 32'h55);

        // Reset during WAIT aborts the store of 0xAA
        req(1'b0, "st8", 1'b0, 1'b1, 32'h8, 32'h11, 3, 1'b0);
        @(posedge clk); #1;
        rd3 = 1'b0; wr3 = 1'b1; addr3 = 32'h8; wdat3 = 32'hAA;
        @(negedge clk);
        chk("abort_stall_T", 32'(stall3), 32'd1);
        @(negedge clk);
        chk("abort_stall_wait", 32'(stall3), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_stall_rst", 32'(stall3), 32'd0);
        chk("abort_done_rst", 32'(done3), 32'd0);
        chk("abort_data_rst", data3, 32'h0);
        wr3 = 1'b0; addr3 = 32'h0; wdat3 = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_nodone", 32'(done3), 32'd0);
        end
        req(1'b0, "ld8", 1'b1, 1'b0, 32'h8, 32'h0, 3, 1'b0);
        chk("ld8_data", data3, 32'h11);
        idle_inputs();

        // LATENCY=1 instance: done at T+1, stall only in T
        req(1'b1, "l1st4", 1'b0, 1'b1, 32'h4, 32'hCAFE, 1, 1'b0);
        req(1'b1, "l1ld4", 1'b1, 1'b0, 32'h4, 32'h0, 1, 1'b0);
        chk("l1ld4_data", data1, 32'hCAFE);
        idle_inputs();
        @(negedge clk);
        chk("end_stall3", 32'(stall3), 32'd0);
        chk("end_stall1", 32'(stall1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
